// File: rtl/pattern_gen.sv
// pattern_gen: test-pattern source for a DVI pipeline with a debounced mode button
// and frame-synchronous mode/box updates.
module pattern_gen #(
    parameter int H_ACTIVE        = 1280,
    parameter int V_ACTIVE        = 720,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BOX             = 64,
    parameter int STEP            = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] column_addr,
    input  logic [9:0]  row_addr,
    input  logic        mode_btn,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic [1:0]  mode
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2, level, pending, prev_nz, dx, dy;
    logic [CW-1:0] deb_cnt;
    logic [7:0]    frame_cnt;
    logic [10:0]   box_x;
    logic [9:0]    box_y;
    logic          at_zero, flip, rise, visible, in_box;
    logic [11:0]   col12, row12, bx12, by12;
    logic [23:0]   pix;

    always_comb begin
        col12   = {1'b0, column_addr};
        row12   = {2'b0, row_addr};
        bx12    = {1'b0, box_x};
        by12    = {2'b0, box_y};
        at_zero = column_addr == 11'd0 && row_addr == 10'd0;
        flip    = sync2 != level && deb_cnt == LAST;
        rise    = flip && sync2;
        visible = col12 < 12'(H_ACTIVE) && row12 < 12'(V_ACTIVE);
        in_box  = col12 >= bx12 && col12 < bx12 + 12'(BOX) &&
                  row12 >= by12 && row12 < by12 + 12'(BOX);
        // Bar colour bits fall straight out of the bar index: r=~i[1], g=~i[2], b=~i[0].
        pix = mode == 2'd0 ? {{8{~column_addr[9]}}, {8{~column_addr[10]}}, {8{~column_addr[8]}}} :
              mode == 2'd1 ? {24{column_addr[5] ^ row_addr[5]}} :
              mode == 2'd2 ? {column_addr[7:0], row_addr[7:0], frame_cnt} :
              in_box       ? 24'hFFFFFF : 24'h000040;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            level       <= 1'b0;
            deb_cnt     <= '0;
            pending     <= 1'b0;
            prev_nz     <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
            mode        <= 2'd0;
            box_x       <= 11'd0;
            box_y       <= 10'd0;
            dx          <= 1'b1;
            dy          <= 1'b1;
            {red, green, blue} <= 24'd0;
        end else begin
            sync1       <= mode_btn;
            sync2       <= sync1;
            level       <= flip ? sync2 : level;
            deb_cnt     <= (sync2 != level && !flip) ? deb_cnt + CW'(1) : '0;
            prev_nz     <= !at_zero;
            frame_start <= at_zero && prev_nz;
            {red, green, blue} <= visible ? pix : 24'd0;
            // An edge coinciding with frame_start survives into the next frame.
            pending     <= rise || (pending && !frame_start);
            if (frame_start) begin
                frame_cnt <= frame_cnt + 8'd1;
                mode      <= pending ? mode + 2'd1 : mode;
                if (dx) begin
                    dx    <= !(bx12 + 12'(BOX + STEP) > 12'(H_ACTIVE));
                    box_x <= (bx12 + 12'(BOX + STEP) > 12'(H_ACTIVE)) ? box_x - 11'(STEP) : box_x + 11'(STEP);
                end else begin
                    dx    <= bx12 < 12'(STEP);
                    box_x <= (bx12 < 12'(STEP)) ? box_x + 11'(STEP) : box_x - 11'(STEP);
                end
                if (dy) begin
                    dy    <= !(by12 + 12'(BOX + STEP) > 12'(V_ACTIVE));
                    box_y <= (by12 + 12'(BOX + STEP) > 12'(V_ACTIVE)) ? box_y - 10'(STEP) : box_y + 10'(STEP);
                end else begin
                    dy    <= by12 < 12'(STEP);
                    box_y <= (by12 < 12'(STEP)) ? box_y + 10'(STEP) : box_y - 10'(STEP);
                end
            end
        end
    end
endmodule
